mem_arb_rr: RTL and testbench
=============================

Name: mem_arb_rr

Overview:
- Parametrised N-port arbiter that time-shares one external 16-bit memory bus (SDRAM/PSRAM/BRAM-style MemBus) between several MemIO-style clients.
- Successor to the fixed two-port edge-request arbiter.
- Generalised in port count, address/data width and access time.
- Adds round-robin fairness, explicit per-port completion acks, write-to-read turnaround and synchronous reset.
- Sits between mapper-side memory clients (BIOS, cart RAM, PCM, backup RAM) and a board memory bus.

Parameters:
PORTS, 4, number of client ports (2..8)
AW, 23, address width (passed through unchanged)
DW, 16, data width
DELAY, 2, cycles a strobe is held on the memory bus before read data is sampled (1..7)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
req_oe  in  PORTS  per-port read request level
req_we_lo  in  PORTS  per-port low-byte write request level
req_we_hi  in  PORTS  per-port high-byte write request level
req_addr  in  PORTS*AW  per-port address, port i at [i*AW +: AW]
req_din  in  PORTS*DW  per-port write data, port i at [i*DW +: DW]
req_dout  out  PORTS*DW  per-port registered read data
req_ack  out  PORTS  one-cycle completion pulse per port
mem_addr  out  AW  memory address
mem_din  out  DW  data to memory
mem_dout  in  DW  data from memory
mem_oe  out  1  memory read strobe
mem_we_lo  out  1  memory low-byte write strobe
mem_we_hi  out  1  memory high-byte write strobe
busy  out  1  high while an access is in progress

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - all mem_* strobes, req_ack, busy and pending bits go to 0;
  - req_dout all 0; mem_addr/mem_din 0; RR pointer 0; state IDLE.
  - Applies even mid-access; the aborted access gets no ack.
- Request detection, per port: act_i = req_oe|req_we_lo|req_we_hi.
  - A rising edge of act_i (act_i=1, previous sample 0) sets pend_i.
  - A level held high does not re-request; the client must drop act_i for at least one cycle to issue another request.
  - A rising edge in the same cycle as pend_i is cleared by a grant to that port is absorbed, not re-queued.
- Arbitration (IDLE, combinational on pend | edge):
  - search ports starting at RR pointer p, wrapping modulo PORTS; first requester wins.
  - On grant to port g: p <= (g+1) mod PORTS.
- States:
  - IDLE → ACCESS on grant at edge E. At E, register:
    - mem_addr, mem_din from port g;
    - mem_oe/mem_we_lo/mem_we_hi from port g's current levels;
    - counter = DELAY, busy = 1.
  - ACCESS: counter decrements each cycle; strobes, address and data are held stable. When counter reaches 0 (edge E+DELAY+1):
    - if mem_oe, capture mem_dout into port g's req_dout slot;
    - drop all strobes, pulse req_ack[g] for exactly one cycle;
    - if the access was a read, go to IDLE, so a new grant may be made at that same edge (back-to-back reads);
    - if it was a write, go to TURN.
  - TURN: one cycle with all strobes low, busy=1, then IDLE. Next write/read grant is at the earliest E+DELAY+2.
- Latency: read data is valid in req_dout and req_ack is high DELAY+1 cycles after the grant edge. Minimum request-edge-to-ack is DELAY+1 cycles when uncontended.
- Strobe combinations: oe with we is passed through as sampled; the memory owner forbids it. Address and data are never modified.
- req_dout slots of non-granted ports hold their last value.
- Worst-case wait for any pending port: (PORTS-1)*(DELAY+2) cycles.

Optional Feature:
MEM_ARB_FIXPRI_EN
- Defined: port 0 is fixed highest priority; it wins whenever pending. Ports 1..PORTS-1 are round-robin among themselves, and the RR pointer never points at 0. Intended for real-time streams such as PCM.
- Undefined: pure round-robin over all ports as above.

Test Plan:
- Reset mid-read (DELAY=2, rst_n low at E+1) → next cycle mem_oe=0, busy=0, no req_ack, all pend cleared, req_dout=0.
- Single read, port 1 addr 0x000123, mem_dout=0xBEEF → mem_oe high for 3 cycles; req_ack[1] pulses once; req_dout slot 1 = 0xBEEF; ack comes 3 cycles after the grant edge.
- Simultaneous read edges on ports 0..3 from reset → grant order 0,1,2,3; acks at gaps of 3 cycles (no turnaround).
- Write port 2 (we_hi only, data 0x5A00) then read port 3 pending → mem_we_hi 3 cycles with mem_we_lo=0; one strobe-free TURN cycle; read grant 4 cycles after write grant.
- Port 0 holds req_oe high for 20 cycles → exactly one ack. Drop for 1 cycle, raise again → second ack.
- With MEM_ARB_FIXPRI_EN, port 0 re-requests after every ack while ports 1 and 2 are pending → port 0 is granted whenever pending. Without the macro, order is 0,1,2,0.

Source files
------------

// File: rtl/mem_arb_rr.sv
// N-port round-robin arbiter sharing one memory bus; ack DELAY+1 cycles after grant, one TURN cycle after writes.
// Optional build macro MEM_ARB_FIXPRI_EN: port 0 fixed highest priority, ports 1..PORTS-1 round-robin.
module mem_arb_rr #(
  parameter int PORTS = 4,
  parameter int AW    = 23,
  parameter int DW    = 16,
  parameter int DELAY = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PORTS-1:0]    req_oe,
  input  logic [PORTS-1:0]    req_we_lo,
  input  logic [PORTS-1:0]    req_we_hi,
  input  logic [PORTS*AW-1:0] req_addr,
  input  logic [PORTS*DW-1:0] req_din,
  output logic [PORTS*DW-1:0] req_dout,
  output logic [PORTS-1:0]    req_ack,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_din,
  input  logic [DW-1:0]       mem_dout,
  output logic                mem_oe,
  output logic                mem_we_lo,
  output logic                mem_we_hi,
  output logic                busy
);

  localparam int PW = $clog2(PORTS);
`ifdef MEM_ARB_FIXPRI_EN
  localparam int LO = 1;
`else
  localparam int LO = 0;
`endif
  localparam logic [PW-1:0] PTR_RST = PW'(LO);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_TURN} state_t;

  state_t              r_state, w_state_nxt;
  logic [PORTS-1:0]    r_act_prev, r_pend, r_ack;
  logic [PW-1:0]       r_ptr, r_gnt;
  logic [2:0]          r_cnt;
  logic [AW-1:0]       r_addr;
  logic [DW-1:0]       r_din;
  logic                r_oe, r_we_lo, r_we_hi;
  logic [PORTS*DW-1:0] r_dout;

  logic [PORTS-1:0]    w_act, w_edge, w_req, w_gnt_oh;
  logic [PW-1:0]       w_gnt_idx, w_ptr_nxt;
  logic                w_gnt_vld, w_cnt_done, w_done, w_rd_done, w_arb_en, w_take;
  logic [AW-1:0]       w_addr;
  logic [DW-1:0]       w_din;
  logic                w_oe, w_we_lo, w_we_hi;

  assign w_act      = req_oe | req_we_lo | req_we_hi;
  assign w_edge     = w_act & ~r_act_prev;
  assign w_req      = r_pend | w_edge;
  assign w_cnt_done = (r_cnt == 3'd0);
  assign w_done     = (r_state == ST_ACCESS) && w_cnt_done;
  assign w_rd_done  = w_done && !r_we_lo && !r_we_hi;
  // A completing read re-arbitrates on the same edge so reads run back to back.
  assign w_arb_en   = (r_state == ST_IDLE) || (r_state == ST_TURN) || w_rd_done;
  assign w_take     = w_arb_en && w_gnt_vld;

  // Two passes: ports at/after the pointer, then the ones that wrapped below it.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
`ifdef MEM_ARB_FIXPRI_EN
    if (w_req[0]) w_gnt_vld = 1'b1;
`endif
    for (int j = LO; j < PORTS; j++) begin
      if (!w_gnt_vld && w_req[j] && j >= int'(r_ptr)) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = PW'(j);
      end
    end
    for (int j = LO; j < PORTS; j++) begin
      if (!w_gnt_vld && w_req[j] && j < int'(r_ptr)) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = PW'(j);
      end
    end
  end

  always_comb begin
    w_ptr_nxt = r_ptr;
    if (int'(w_gnt_idx) == PORTS - 1) w_ptr_nxt = PTR_RST;
    else if (int'(w_gnt_idx) >= LO)   w_ptr_nxt = w_gnt_idx + PW'(1);
  end

  always_comb begin
    w_addr   = '0;
    w_din    = '0;
    w_oe     = 1'b0;
    w_we_lo  = 1'b0;
    w_we_hi  = 1'b0;
    w_gnt_oh = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (PW'(i) == w_gnt_idx) begin
        w_addr      = req_addr[i*AW +: AW];
        w_din       = req_din[i*DW +: DW];
        w_oe        = req_oe[i];
        w_we_lo     = req_we_lo[i];
        w_we_hi     = req_we_hi[i];
        w_gnt_oh[i] = w_take;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_take) w_state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (w_cnt_done) begin
          if (r_we_lo || r_we_hi) w_state_nxt = ST_TURN;
          else if (w_take)        w_state_nxt = ST_ACCESS;
          else                    w_state_nxt = ST_IDLE;
        end
      end
      ST_TURN:   w_state_nxt = w_take ? ST_ACCESS : ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_act_prev <= '0;
      r_pend     <= '0;
      r_ack      <= '0;
      r_ptr      <= PTR_RST;
      r_gnt      <= '0;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_din      <= '0;
      r_oe       <= 1'b0;
      r_we_lo    <= 1'b0;
      r_we_hi    <= 1'b0;
      r_dout     <= '0;
    end else begin
      r_ack      <= '0;
      r_act_prev <= w_act;
      r_pend     <= w_req & ~w_gnt_oh;
      if (r_state == ST_ACCESS && !w_cnt_done) r_cnt <= r_cnt - 3'd1;
      if (w_done) begin
        for (int i = 0; i < PORTS; i++) begin
          if (PW'(i) == r_gnt) begin
            r_ack[i] <= 1'b1;
            if (r_oe) r_dout[i*DW +: DW] <= mem_dout;
          end
        end
        r_oe    <= 1'b0;
        r_we_lo <= 1'b0;
        r_we_hi <= 1'b0;
      end
      if (w_take) begin
        r_gnt   <= w_gnt_idx;
        r_ptr   <= w_ptr_nxt;
        r_addr  <= w_addr;
        r_din   <= w_din;
        r_oe    <= w_oe;
        r_we_lo <= w_we_lo;
        r_we_hi <= w_we_hi;
        r_cnt   <= 3'(DELAY);
      end
    end
  end

  assign req_dout  = r_dout;
  assign req_ack   = r_ack;
  assign mem_addr  = r_addr;
  assign mem_din   = r_din;
  assign mem_oe    = r_oe;
  assign mem_we_lo = r_we_lo;
  assign mem_we_hi = r_we_hi;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_arb_rr.sv
// Directed bench for mem_arb_rr (PORTS=4, DELAY=2); memory returns addr[15:0] ^ 0xBFCC.
module tb_mem_arb_rr;
  localparam int PORTS = 4;
  localparam int AW    = 23;
  localparam int DW    = 16;
  localparam int DELAY = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [PORTS-1:0]    req_oe, req_we_lo, req_we_hi;
  logic [PORTS*AW-1:0] req_addr;
  logic [PORTS*DW-1:0] req_din;
  logic [PORTS*DW-1:0] req_dout;
  logic [PORTS-1:0]    req_ack;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_din;
  logic [DW-1:0]       mem_dout;
  logic                mem_oe, mem_we_lo, mem_we_hi, busy;

  int n_vec = 0;
  int n_err = 0;
  int acks;

  always #5 clk = ~clk;

  assign mem_dout = mem_addr[15:0] ^ 16'hBFCC;

  mem_arb_rr #(.PORTS(PORTS), .AW(AW), .DW(DW), .DELAY(DELAY)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_oe(req_oe), .req_we_lo(req_we_lo), .req_we_hi(req_we_hi),
    .req_addr(req_addr), .req_din(req_din), .req_dout(req_dout), .req_ack(req_ack),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_oe(mem_oe), .mem_we_lo(mem_we_lo), .mem_we_hi(mem_we_hi), .busy(busy)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_oe = '0; req_we_lo = '0; req_we_hi = '0;
    req_addr = '0; req_din = '0;
    step; step;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_oe",   32'(mem_oe), 32'd0);
    chk("rst_ack",  32'(req_ack), 32'd0);
    chk("rst_dout", 32'(req_dout[31:0]), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);

    // single read on port 1
    rst_n = 1'b1; step;
    req_addr[1*AW +: AW] = 23'h000123; req_oe[1] = 1'b1;
    step;
    chk("rd1_oe_e0",  32'(mem_oe), 32'd1);
    chk("rd1_addr",   32'(mem_addr), 32'h123);
    chk("rd1_busy",   32'(busy), 32'd1);
    chk("rd1_ack_e0", 32'(req_ack), 32'd0);
    step; chk("rd1_oe_e1", 32'(mem_oe), 32'd1);
    step; chk("rd1_oe_e2", 32'(mem_oe), 32'd1);
    chk("rd1_ack_e2", 32'(req_ack), 32'd0);
    step;
    chk("rd1_ack",   32'(req_ack), 32'b0010);
    chk("rd1_dout",  32'(req_dout[1*DW +: DW]), 32'hBEEF);
    chk("rd1_oe_off", 32'(mem_oe), 32'd0);
    chk("rd1_idle",  32'(busy), 32'd0);
    req_oe[1] = 1'b0; step;
    chk("rd1_ack_once", 32'(req_ack), 32'd0);

    // reset one cycle into a read
    req_addr[3*AW +: AW] = 23'h000042; req_oe = 4'b1001;
    step;
    chk("rstm_gnt3", 32'(mem_addr), 32'h42);
    chk("rstm_oe_on", 32'(mem_oe), 32'd1);
    rst_n = 1'b0; req_oe = '0;
    step;
    chk("rstm_oe",   32'(mem_oe), 32'd0);
    chk("rstm_busy", 32'(busy), 32'd0);
    chk("rstm_ack",  32'(req_ack), 32'd0);
    chk("rstm_dout", 32'(req_dout[31:0]), 32'd0);
    step; chk("rstm_ack2", 32'(req_ack), 32'd0);
    rst_n = 1'b1; step; step; step;
    chk("rstm_nopend_busy", 32'(busy), 32'd0);
    chk("rstm_nopend_oe",   32'(mem_oe), 32'd0);
    chk("rstm_nopend_ack",  32'(req_ack), 32'd0);

    // four simultaneous reads, back to back
    for (int i = 0; i < PORTS; i++) req_addr[i*AW +: AW] = 23'(256 + i);
    req_oe = 4'hF;
    step;
    chk("rr_addr0", 32'(mem_addr), 32'h100);
    step; step; step;
    chk("rr_ack0",  32'(req_ack), 32'b0001);
    chk("rr_dout0", 32'(req_dout[0*DW +: DW]), 32'hBECC);
    chk("rr_addr1", 32'(mem_addr), 32'h101);
    chk("rr_oe_b2b", 32'(mem_oe), 32'd1);
    step; chk("rr_gap", 32'(req_ack), 32'd0);
    step; step;
    chk("rr_ack1",  32'(req_ack), 32'b0010);
    chk("rr_dout1", 32'(req_dout[1*DW +: DW]), 32'hBECD);
    chk("rr_addr2", 32'(mem_addr), 32'h102);
    step; step; step;
    chk("rr_ack2",  32'(req_ack), 32'b0100);
    chk("rr_dout2", 32'(req_dout[2*DW +: DW]), 32'hBECE);
    chk("rr_addr3", 32'(mem_addr), 32'h103);
    step; step; step;
    chk("rr_ack3",  32'(req_ack), 32'b1000);
    chk("rr_dout3", 32'(req_dout[3*DW +: DW]), 32'hBECF);
    chk("rr_idle",  32'(busy), 32'd0);
    req_oe = '0; step;

    // high-byte write on port 2, then pending read on port 3
    req_addr[2*AW +: AW] = 23'h200; req_din[2*DW +: DW] = 16'h5A00;
    req_addr[3*AW +: AW] = 23'h300;
    req_we_hi[2] = 1'b1; req_oe[3] = 1'b1;
    step;
    chk("wr_hi",   32'(mem_we_hi), 32'd1);
    chk("wr_lo",   32'(mem_we_lo), 32'd0);
    chk("wr_oe",   32'(mem_oe), 32'd0);
    chk("wr_din",  32'(mem_din), 32'h5A00);
    chk("wr_addr", 32'(mem_addr), 32'h200);
    step; step;
    chk("wr_hi_e2", 32'(mem_we_hi), 32'd1);
    step;
    chk("wr_ack",      32'(req_ack), 32'b0100);
    chk("wr_turn_hi",  32'(mem_we_hi), 32'd0);
    chk("wr_turn_oe",  32'(mem_oe), 32'd0);
    chk("wr_turn_busy", 32'(busy), 32'd1);
    chk("wr_dout_keep", 32'(req_dout[2*DW +: DW]), 32'hBECE);
    step;
    chk("wr_rd_oe",   32'(mem_oe), 32'd1);
    chk("wr_rd_addr", 32'(mem_addr), 32'h300);
    step; step; step;
    chk("wr_rd_ack",  32'(req_ack), 32'b1000);
    chk("wr_rd_dout", 32'(req_dout[3*DW +: DW]), 32'hBCCC);
    req_we_hi = '0; req_oe = '0; step;

    // held level gives one ack; drop and raise gives another
    req_oe[0] = 1'b1; acks = 0;
    for (int k = 0; k < 20; k++) begin
      step;
      if (req_ack[0]) acks++;
    end
    chk("hold_one_ack", 32'(acks), 32'd1);
    req_oe[0] = 1'b0; step;
    req_oe[0] = 1'b1; acks = 0;
    for (int k = 0; k < 6; k++) begin
      step;
      if (req_ack[0]) acks++;
    end
    chk("reraise_ack", 32'(acks), 32'd1);
    req_oe = '0; step;

    // port 0 re-requests while ports 1 and 2 wait
    rst_n = 1'b0; step; rst_n = 1'b1; step;
    req_oe = 4'b0111;
    step; step; step; step;
    chk("ord0", 32'(req_ack), 32'b0001);
    req_oe[0] = 1'b0; step;
    req_oe[0] = 1'b1; step;
    step;
    chk("ord1", 32'(req_ack), 32'b0010);
    step; step; step;
`ifdef MEM_ARB_FIXPRI_EN
    chk("ord2", 32'(req_ack), 32'b0001);
`else
    chk("ord2", 32'(req_ack), 32'b0100);
`endif
    step; step; step;
`ifdef MEM_ARB_FIXPRI_EN
    chk("ord3", 32'(req_ack), 32'b0100);
`else
    chk("ord3", 32'(req_ack), 32'b0001);
`endif
    req_oe = '0; step;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
